// File: rtl/vertex_loader_if.sv
// Vertex stream plus BRAM write-port bundle; master drives the stream and
// watches the BRAM port, slave is the loader.
interface vertex_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wdata;

  modport master (output i_valid, i_data, i_last, input  o_ready, o_we, o_addr, o_wdata);
  modport slave  (input  i_valid, i_data, i_last, output o_ready, o_we, o_addr, o_wdata);
endinterface

// File: rtl/vertex_loader.sv
// Packs a vertex word stream into fixed-size records in the vertex BRAM and
// counts complete records so the geometry engine only sees whole meshes.
module vertex_loader #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 10,
  parameter int WORDS_PER_VERTEX = 5,
  parameter int MAX_VERTICES     = 204
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  vertex_loader_if.slave        io_bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_vertex_count
);
  localparam int FW = (WORDS_PER_VERTEX > 1) ? $clog2(WORDS_PER_VERTEX) : 1;
  localparam logic [FW-1:0]         LAST_FIELD = FW'(WORDS_PER_VERTEX - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT    = ADDR_WIDTH'(MAX_VERTICES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                r_state;
  logic [FW-1:0]         r_field;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_done;
  logic                  r_error;
  logic                  r_ready;

  logic w_accept;
  logic w_full;

  assign w_accept = io_bus.i_valid & r_ready;
  // Once the table is full, words are swallowed so upstream can reach i_last.
  assign w_full   = (r_count == MAX_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_field <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_ready <= 1'b1;
            r_field <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_full) begin
              r_error <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= io_bus.i_data;
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              if (r_field == LAST_FIELD) begin
                r_field <= '0;
                r_count <= r_count + ADDR_WIDTH'(1);
              end else begin
                r_field <= r_field + FW'(1);
              end
            end
            // A mesh ending mid-record still lands in BRAM but is flagged.
            if (io_bus.i_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
              if (r_field != LAST_FIELD) r_error <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_ready  = r_ready;
  assign io_bus.o_we     = r_we;
  assign io_bus.o_addr   = r_waddr;
  assign io_bus.o_wdata  = r_wdata;
  assign o_busy          = r_ready;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_vertex_count  = r_count;
endmodule
